// File: rtl/nibble_serial_subtractor.sv
// -----------------------------------------------------------------------------
// nibble_serial_subtractor
//
// Multi-cycle two's-complement subtractor: diff = a - b - bin (modulo 2^WIDTH).
// A single 4-bit slice is reused once per clock, least significant nibble
// first. The borrow is carried between nibbles as a registered "carry" in
// add-the-complement form (carry = ~borrow), so each step is a plain
// a_nib + ~b_nib + carry.
//
// Optional feature macro: OVERFLOW_DETECT_EN
//   defined   -> port ovf is present (signed overflow flag, registered)
//   undefined -> port ovf and its logic are absent
//
// Parameters
//   WIDTH      operand/result width, multiple of 4 and >= 4 (default 16)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands valid (sampled only in IDLE)
//   in_ready   block can accept operands (combinational decode of IDLE)
//   a, b       minuend / subtrahend
//   bin        borrow in
//   out_valid  result valid, held until out_ready
//   out_ready  consumer accepts result
//   diff       a - b - bin, modulo 2^WIDTH
//   bout       borrow out, 1 iff unsigned a < b + bin
//   ovf        signed overflow (OVERFLOW_DETECT_EN only)
// -----------------------------------------------------------------------------
module nibble_serial_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef OVERFLOW_DETECT_EN
  ,
  output logic             ovf
`endif
);

  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // One nibble step of a - b expressed as a + ~b + carry; bit 4 is the carry.
  function automatic logic [4:0] nib_sub(input logic [3:0] a_n,
                                         input logic [3:0] b_n,
                                         input logic       cin);
    nib_sub = {1'b0, a_n} + {1'b0, ~b_n} + {4'b0000, cin};
  endfunction

`ifdef OVERFLOW_DETECT_EN
  // Signed overflow of a - b: operand signs differ and result sign differs
  // from the minuend sign.
  function automatic logic sub_ovf(input logic a_msb,
                                   input logic b_msb,
                                   input logic d_msb);
    sub_ovf = (a_msb != b_msb) && (d_msb != a_msb);
  endfunction
`endif

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             carry_r;
  logic [IDXW-1:0]  idx_r;
  logic [WIDTH-1:0] diff_r;
  logic             bout_r;
  logic             out_valid_r;
`ifdef OVERFLOW_DETECT_EN
  logic             ovf_r;
`endif

  logic [3:0]       a_nib_s;
  logic [3:0]       b_nib_s;
  logic [4:0]       sum_s;
  logic             last_s;

  // Select the nibble pair addressed by idx and run the shared slice.
  always_comb begin
    a_nib_s = a_r[{idx_r, 2'b00} +: 4];
    b_nib_s = b_r[{idx_r, 2'b00} +: 4];
    sum_s   = nib_sub(a_nib_s, b_nib_s, carry_r);
    last_s  = (idx_r == LAST_IDX);
  end

  // Next-state decode for IDLE -> CALC -> DONE -> IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_nxt_s = CALC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CALC: begin
        if (last_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = CALC;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, operand latch, nibble-serial datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      carry_r     <= 1'b0;
      idx_r       <= {IDXW{1'b0}};
      diff_r      <= {WIDTH{1'b0}};
      bout_r      <= 1'b0;
      out_valid_r <= 1'b0;
`ifdef OVERFLOW_DETECT_EN
      ovf_r       <= 1'b0;
`endif
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r     <= a;
            b_r     <= b;
            // No incoming borrow means the +1 of the two's complement.
            carry_r <= ~bin;
            idx_r   <= {IDXW{1'b0}};
          end
        end
        CALC: begin
          diff_r[{idx_r, 2'b00} +: 4] <= sum_s[3:0];
          carry_r                     <= sum_s[4];
          idx_r                       <= idx_r + IDXW'(1);
          if (last_s) begin
            bout_r      <= ~sum_s[4];
            out_valid_r <= 1'b1;
`ifdef OVERFLOW_DETECT_EN
            // The top nibble's bit 3 is the result sign bit.
            ovf_r       <= sub_ovf(a_r[WIDTH-1], b_r[WIDTH-1], sum_s[3]);
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (state_r == IDLE);
  assign out_valid = out_valid_r;
  assign diff      = diff_r;
  assign bout      = bout_r;
`ifdef OVERFLOW_DETECT_EN
  assign ovf       = ovf_r;
`endif

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// -----------------------------------------------------------------------------
// Bench for nibble_serial_subtractor (WIDTH=16). Stimulus pushes the
// hand-computed expected result into a queue; an independent monitor pops and
// compares whenever the DUT completes an output handshake.
// -----------------------------------------------------------------------------
module tb_nibble_serial_subtractor;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] diff;
  logic        bout;
`ifdef OVERFLOW_DETECT_EN
  logic        ovf;
`endif

  typedef struct packed {
    logic [15:0] d;
    logic        bo;
    logic        ov;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  nibble_serial_subtractor #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout)
`ifdef OVERFLOW_DETECT_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  // Monitor: compare every completed output handshake against the queue.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 32'(diff), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_diff", 32'(diff), 32'(e.d));
        check("sb_bout", 32'(bout), 32'(e.bo));
`ifdef OVERFLOW_DETECT_EN
        check("sb_ovf", 32'(ovf), 32'(e.ov));
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [15:0] av, input logic [15:0] bv, input logic bi,
                       input logic [15:0] ed, input logic eb, input logic eo);
    exp_t e;
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (!in_ready) check("issue_timeout", 32'(in_ready), 32'd1);
    e.d = ed; e.bo = eb; e.ov = eo;
    exp_q.push_back(e);
    a = av; b = bv; bin = bi; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    // Operands are taken only on the accepting edge; scramble them now.
    a = 16'hDEAD; b = 16'hBEEF; bin = 1'b1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = 16'h0000; b = 16'h0000;
    bin = 1'b0; out_ready = 1'b1;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef OVERFLOW_DETECT_EN
    check("rst_ovf", 32'(ovf), 32'd0);
`endif
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // 1: basic op and exact latency.
    begin
      exp_t e;
      e.d = 16'h1000; e.bo = 1'b0; e.ov = 1'b0;
      exp_q.push_back(e);
      a = 16'h1234; b = 16'h0234; bin = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0; a = 16'h5555; b = 16'hAAAA;
      check("t1_busy_ready", 32'(in_ready), 32'd0);
      for (int i = 1; i <= 3; i++) begin
        tick();
        check("t1_latency_early", 32'(out_valid), 32'd0);
      end
      tick();
      check("t1_latency_4", 32'(out_valid), 32'd1);
      check("t1_diff", 32'(diff), 32'h1000);
      check("t1_done_ready", 32'(in_ready), 32'd0);
      tick();
      check("t1_ready_again", 32'(in_ready), 32'd1);
      check("t1_valid_drop", 32'(out_valid), 32'd0);
    end

    // 2: wrap-around and borrow-in.
    issue(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    drain();
    issue(16'h0005, 16'h0003, 1'b1, 16'h0001, 1'b0, 1'b0);
    drain();
    issue(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    drain();

    // 3: backpressure with competing in_valid.
    out_ready = 1'b0;
    issue(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);
    begin
      int n;
      n = 0;
      while (!out_valid && n < 20) begin
        tick();
        n++;
      end
      check("t3_valid_seen", 32'(out_valid), 32'd1);
    end
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; a = 16'h7777; b = 16'h1111; bin = 1'b0;
      tick();
      check("t3_hold_valid", 32'(out_valid), 32'd1);
      check("t3_hold_diff", 32'(diff), 32'h1000);
      check("t3_hold_bout", 32'(bout), 32'd0);
      check("t3_hold_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("t3_release_valid", 32'(out_valid), 32'd0);
    check("t3_release_ready", 32'(in_ready), 32'd1);
    check("t3_queue_empty", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < 8; i++) tick();
    check("t3_no_extra_op", 32'(out_valid), 32'd0);

    // 4: borrow chain through nibbles 0..2.
    issue(16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0);
    drain();

    // 5: reset mid-CALC aborts the operation.
    a = 16'h1111; b = 16'h0001; bin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", 32'(out_valid), 32'd0);
    check("t5_rst_diff", 32'(diff), 32'd0);
    check("t5_rst_ready", 32'(in_ready), 32'd1);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    issue(16'h0009, 16'h0004, 1'b0, 16'h0005, 1'b0, 1'b0);
    drain();

    // 6: signed overflow cases (ovf compared only when the port exists).
    issue(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
    drain();
    issue(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);
    drain();
    issue(16'h0003, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);
    drain();
    issue(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b0, 1'b0);
    drain();

    for (int i = 0; i < 10; i++) tick();
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
